io_bus_arbiter: RTL and testbench
=================================

// Module: io_bus_arbiter
// PURPOSE
//  Shares the single-cycle peripheral bus between two masters: m0 = yarvi core, m1 = debug/loader.
//  - Slave side feeds the address-decoded peripherals (rs232 at address[29]).
//  - Round-robin arbitration; losing master is stalled via waitrequest.
//  - Returning read data is routed to the issuing master through a tag pipeline.
// PARAMETERS
//  ADDR_W        30  word-address width
//  DATA_W        32  data width
//  READ_LATENCY  1   cycles from s_readenable to valid s_readdata (1..4)
// PORTS
//  clk               in   1         single clock, rising edge
//  reset             in   1         asynchronous, active-high
//  mN_address        in   ADDR_W    N=0,1; word address
//  mN_writeenable    in   1         write request
//  mN_writedata      in   DATA_W    write data
//  mN_byteena        in   DATA_W/8  byte enables
//  mN_readenable     in   1         read request
//  mN_waitrequest    out  1         1 = request not accepted this cycle; hold all mN_* stable
//  mN_readdata       out  DATA_W    = s_readdata
//  mN_readdatavalid  out  1         1-cycle pulse: mN_readdata is this master's read result
//  s_address         out  ADDR_W    to peripherals
//  s_writeenable     out  1
//  s_writedata       out  DATA_W
//  s_byteena         out  DATA_W/8
//  s_readenable      out  1
//  s_readdata        in   DATA_W    valid READ_LATENCY cycles after s_readenable
// BEHAVIOUR
//  - reqN = mN_readenable | mN_writeenable. Grant is combinational, same-cycle; accept latency 0.
//  - Grant rule:
//    - Only one master requesting: that master wins.
//    - Both requesting: the master other than last_grant wins.
//    - Neither: no grant; last_grant unchanged.
//  - last_grant register: loads the winner on each granted cycle. Reset value 1, so m0 wins the first tie.
//  - Slave outputs:
//    - s_* mux from the granted master. With no grant they mux m0, with s_writeenable = s_readenable = 0.
//    - Enables are forwarded only for the winner.
//    - Both enables set together in one master: both are forwarded unchanged (no check).
//  - mN_waitrequest = reqN & ~grantN, combinational. 0 when not requesting.
//  - Read tag pipeline:
//    - READ_LATENCY stages of {valid, id}. Stage 0 loads {s_readenable, granted id} every cycle.
//    - Shifts every cycle; never stalls. Back-to-back reads from either master are allowed.
//    - Last stage: mN_readdatavalid = valid & (id == N). At most one master is valid per cycle; results return in issue order.
//  - Writes have no response; accepted = retired.
//  - Reset values: last_grant = 1, all tag valids = 0.
//    - All outputs settle combinationally from requests. After reset with no requests: every waitrequest, readdatavalid and s_* enable is 0.
//  - Reset mid-operation clears in-flight tags. Reads issued before reset never raise readdatavalid.
//  - Requests during reset: grants still resolve combinationally; last_grant holds at 1.
// STRUCTURE
//  - Shared package riscvsoc_bus_pkg:
//    - ADDR_W, DATA_W, BE_W localparams
//    - typedef master_id_t (1 bit)
//    - typedef bus_req_t {address, writeenable, writedata, byteena, readenable}
//  - One sub-module, read_tag_pipe:
//    - Parameterised shift register of {valid, id}, depth READ_LATENCY, asynchronous clear.
//  - Top: grant logic, last_grant flop, output muxes.
// TESTING
//  1. m0 writes 0x41, byteena 4'h1, to 0x20000000 alone
//     -> s_writeenable=1 same cycle, s_address=0x20000000, m0_waitrequest=0.
//  2. First cycle after reset, both write
//     -> cycle0: m0 granted, m1_waitrequest=1. cycle1: m1 granted, m0 idle.
//  3. Both hold requests for 4 cycles -> grants 0,1,0,1; each waitrequest toggles opposite to grant.
//  4. READ_LATENCY=1: m1 reads 0x20000000; slave returns 0x000000A5 next cycle
//     -> m1_readdatavalid=1 for exactly 1 cycle, m1_readdata=0xA5, m0_readdatavalid=0.
//  5. READ_LATENCY=2: both read continuously for 6 cycles
//     -> valids alternate m0,m1,... starting 2 cycles after first accept; no gaps, no drops.
//  6. m0 read accepted, reset pulsed next cycle
//     -> no readdatavalid afterwards; next tie goes to m0.

Source files
------------

// File: rtl/riscvsoc_bus_pkg.sv
// Shared bus types and widths for the peripheral-bus arbiter slice.
package riscvsoc_bus_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              writeenable;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteena;
    logic              readenable;
  } bus_req_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Fixed-latency shift register of {valid, id} tags that follows each read
// through the slave so its data can be steered back to the issuing master.
module read_tag_pipe
  import riscvsoc_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  master_id_t i_id,
  output logic       o_valid,
  output master_id_t o_id
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_id;

  // Load stage 0 every cycle and shift unconditionally; reset drops in-flight tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_id    <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_id[0]    <= i_id;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_id[i]    <= r_id[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the single-cycle peripheral bus.
// m0 = yarvi core, m1 = debug/loader; read data is routed back by tag.
module io_bus_arbiter
  import riscvsoc_bus_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_writeenable,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteena,
  input  logic              m0_readenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_writeenable,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteena,
  input  logic              m1_readenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_writeenable,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteena,
  output logic              s_readenable,
  input  logic [DATA_W-1:0] s_readdata
);

  bus_req_t   w_m0_req;
  bus_req_t   w_m1_req;
  bus_req_t   w_sel;
  logic       w_req0;
  logic       w_req1;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_any;
  master_id_t w_win_id;
  master_id_t r_last_grant;
  logic       w_tag_valid;
  master_id_t w_tag_id;

  // Bundle each master's request fields for the output mux.
  always_comb begin
    w_m0_req = '{address: m0_address, writeenable: m0_writeenable,
                 writedata: m0_writedata, byteena: m0_byteena,
                 readenable: m0_readenable};
    w_m1_req = '{address: m1_address, writeenable: m1_writeenable,
                 writedata: m1_writedata, byteena: m1_byteena,
                 readenable: m1_readenable};
  end

  // Same-cycle grant: a lone requester wins, a tie goes to the master not granted last.
  always_comb begin
    w_req0   = m0_readenable | m0_writeenable;
    w_req1   = m1_readenable | m1_writeenable;
    w_grant0 = w_req0 & (~w_req1 | (r_last_grant == M1));
    w_grant1 = w_req1 & (~w_req0 | (r_last_grant == M0));
    w_any    = w_grant0 | w_grant1;
    w_win_id = w_grant1 ? M1 : M0;
  end

  // Remember the most recent winner; idle cycles leave it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= M1;
    end else if (w_any) begin
      r_last_grant <= w_win_id;
    end
  end

  // Route the winner to the slave; with no grant m0 is muxed with enables forced low.
  always_comb begin
    w_sel = w_grant1 ? w_m1_req : w_m0_req;
    if (!w_any) begin
      w_sel.writeenable = 1'b0;
      w_sel.readenable  = 1'b0;
    end
  end

  assign s_address     = w_sel.address;
  assign s_writeenable = w_sel.writeenable;
  assign s_writedata   = w_sel.writedata;
  assign s_byteena     = w_sel.byteena;
  assign s_readenable  = w_sel.readenable;

  assign m0_waitrequest = w_req0 & ~w_grant0;
  assign m1_waitrequest = w_req1 & ~w_grant1;

  read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_read_tag_pipe (
    .clk     (clk),
    .rst     (reset),
    .i_valid (w_sel.readenable),
    .i_id    (w_win_id),
    .o_valid (w_tag_valid),
    .o_id    (w_tag_id)
  );

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = w_tag_valid & (w_tag_id == M0);
  assign m1_readdatavalid = w_tag_valid & (w_tag_id == M1);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: two instances (read latency 1 and 2) share the
// stimulus; a cycle-indexed issue log predicts grants and read returns.
module tb_io_bus_arbiter;
  import riscvsoc_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address, m1_address;
  logic              m0_writeenable, m1_writeenable;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic [BE_W-1:0]   m0_byteena, m1_byteena;
  logic              m0_readenable, m1_readenable;
  logic [DATA_W-1:0] s_readdata;

  logic              d1_m0_wait, d1_m1_wait, d1_m0_rdv, d1_m1_rdv;
  logic [DATA_W-1:0] d1_m0_rd, d1_m1_rd, d1_s_wd;
  logic [ADDR_W-1:0] d1_s_addr;
  logic              d1_s_we, d1_s_re;
  logic [BE_W-1:0]   d1_s_be;

  logic              d2_m0_wait, d2_m1_wait, d2_m0_rdv, d2_m1_rdv;
  logic [DATA_W-1:0] d2_m0_rd, d2_m1_rd, d2_s_wd;
  logic [ADDR_W-1:0] d2_s_addr;
  logic              d2_s_we, d2_s_re;
  logic [BE_W-1:0]   d2_s_be;

  io_bus_arbiter #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writeenable(m0_writeenable), .m0_writedata(m0_writedata),
    .m0_byteena(m0_byteena), .m0_readenable(m0_readenable), .m0_waitrequest(d1_m0_wait),
    .m0_readdata(d1_m0_rd), .m0_readdatavalid(d1_m0_rdv),
    .m1_address(m1_address), .m1_writeenable(m1_writeenable), .m1_writedata(m1_writedata),
    .m1_byteena(m1_byteena), .m1_readenable(m1_readenable), .m1_waitrequest(d1_m1_wait),
    .m1_readdata(d1_m1_rd), .m1_readdatavalid(d1_m1_rdv),
    .s_address(d1_s_addr), .s_writeenable(d1_s_we), .s_writedata(d1_s_wd),
    .s_byteena(d1_s_be), .s_readenable(d1_s_re), .s_readdata(s_readdata)
  );

  io_bus_arbiter #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writeenable(m0_writeenable), .m0_writedata(m0_writedata),
    .m0_byteena(m0_byteena), .m0_readenable(m0_readenable), .m0_waitrequest(d2_m0_wait),
    .m0_readdata(d2_m0_rd), .m0_readdatavalid(d2_m0_rdv),
    .m1_address(m1_address), .m1_writeenable(m1_writeenable), .m1_writedata(m1_writedata),
    .m1_byteena(m1_byteena), .m1_readenable(m1_readenable), .m1_waitrequest(d2_m1_wait),
    .m1_readdata(d2_m1_rd), .m1_readdatavalid(d2_m1_rdv),
    .s_address(d2_s_addr), .s_writeenable(d2_s_we), .s_writedata(d2_s_wd),
    .s_byteena(d2_s_be), .s_readenable(d2_s_re), .s_readdata(s_readdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: who won last, and a log of what was issued in each cycle.
  bit m_last;
  int cyc;
  int epoch;
  bit hv [0:4095];
  bit hid[0:4095];
  bit e_any, e_win, e_re;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rdv(input int lat, input bit id);
    int c;
    c = cyc - lat;
    return (c >= epoch) && hv[c] && (hid[c] == id);
  endfunction

  // Compare both instances against the rule-level prediction for this cycle.
  task automatic half();
    bit r0, r1, w0, w1;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [BE_W-1:0]   eb;
    @(negedge clk);
    r0 = m0_readenable | m0_writeenable;
    r1 = m1_readenable | m1_writeenable;
    e_any = r0 | r1;
    if (r0 && r1) e_win = ~m_last;
    else          e_win = r1;
    ea = e_win ? m1_address : m0_address;
    ed = e_win ? m1_writedata : m0_writedata;
    eb = e_win ? m1_byteena : m0_byteena;
    w0 = e_win ? m1_writeenable : m0_writeenable;
    e_re = e_win ? m1_readenable : m0_readenable;
    w1 = r1 && !e_win;
    check("d1_wait0", d1_m0_wait, r0 && e_win);
    check("d1_wait1", d1_m1_wait, w1);
    check("d2_wait0", d2_m0_wait, r0 && e_win);
    check("d2_wait1", d2_m1_wait, w1);
    check("d1_s_addr", d1_s_addr, ea);
    check("d1_s_wd", d1_s_wd, ed);
    check("d1_s_be", d1_s_be, eb);
    check("d1_s_we", d1_s_we, w0);
    check("d1_s_re", d1_s_re, e_re);
    check("d2_s_addr", d2_s_addr, ea);
    check("d2_s_we", d2_s_we, w0);
    check("d2_s_re", d2_s_re, e_re);
    check("d1_m0_rd", d1_m0_rd, s_readdata);
    check("d2_m1_rd", d2_m1_rd, s_readdata);
    check("d1_m0_rdv", d1_m0_rdv, exp_rdv(1, 1'b0));
    check("d1_m1_rdv", d1_m1_rdv, exp_rdv(1, 1'b1));
    check("d2_m0_rdv", d2_m0_rdv, exp_rdv(2, 1'b0));
    check("d2_m1_rdv", d2_m1_rdv, exp_rdv(2, 1'b1));
  endtask

  task automatic edge_();
    @(posedge clk);
    if (reset) begin
      hv[cyc] = 1'b0;
      m_last  = 1'b1;
    end else begin
      hv[cyc]  = e_re;
      hid[cyc] = e_win;
      if (e_any) m_last = e_win;
    end
    cyc++;
    #1;
  endtask

  task automatic tick();
    half();
    edge_();
  endtask

  task automatic idle();
    m0_writeenable = 1'b0; m0_readenable = 1'b0;
    m1_writeenable = 1'b0; m1_readenable = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b1;
    m_last = 1'b1;
    epoch  = cyc;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic set_m0(input bit we, input bit re, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    m0_writeenable = we; m0_readenable = re; m0_address = a;
    m0_writedata = d; m0_byteena = be;
  endtask

  task automatic set_m1(input bit we, input bit re, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    m1_writeenable = we; m1_readenable = re; m1_address = a;
    m1_writedata = d; m1_byteena = be;
  endtask

  initial begin
    cyc = 0; epoch = 0; m_last = 1'b1;
    for (int i = 0; i < 4096; i++) begin hv[i] = 1'b0; hid[i] = 1'b0; end
    reset = 1'b1;
    s_readdata = '0;
    set_m0(0, 0, '0, '0, '0);
    set_m1(0, 0, '0, '0, '0);
    #1;
    do_reset(2);

    // Reset state with no requests.
    half();
    check("idle_we", d1_s_we, 1'b0);
    check("idle_wait0", d1_m0_wait, 1'b0);
    edge_();

    // 1: lone m0 write is forwarded with no wait.
    set_m0(1, 0, 30'h2000_0000, 32'h41, 4'h1);
    half();
    check("t1_we", d1_s_we, 1'b1);
    check("t1_addr", d1_s_addr, 30'h2000_0000);
    check("t1_wait0", d1_m0_wait, 1'b0);
    edge_();
    idle(); tick();

    // 2: first tie after reset goes to m0, then m1 alone.
    do_reset(1);
    set_m0(1, 0, 30'h0000_0010, 32'h1111_1111, 4'hF);
    set_m1(1, 0, 30'h0000_0020, 32'h2222_2222, 4'hF);
    half();
    check("t2_c0_addr", d1_s_addr, 30'h0000_0010);
    check("t2_c0_wait1", d1_m1_wait, 1'b1);
    edge_();
    m0_writeenable = 1'b0;
    half();
    check("t2_c1_addr", d1_s_addr, 30'h0000_0020);
    check("t2_c1_wait1", d1_m1_wait, 1'b0);
    edge_();

    // 3: continuous tie alternates 0,1,0,1.
    m0_writeenable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      half();
      check("t3_wait0", d1_m0_wait, (i % 2) == 1);
      check("t3_wait1", d1_m1_wait, (i % 2) == 0);
      edge_();
    end
    idle(); tick();

    // 4: m1 read returns next cycle with latency 1.
    set_m1(0, 1, 30'h2000_0000, '0, 4'hF);
    tick();
    idle();
    s_readdata = 32'h0000_00A5;
    half();
    check("t4_rdv1", d1_m1_rdv, 1'b1);
    check("t4_rd1", d1_m1_rd, 32'h0000_00A5);
    check("t4_rdv0", d1_m0_rdv, 1'b0);
    edge_();
    half();
    check("t4_rdv1_off", d1_m1_rdv, 1'b0);
    edge_();

    // 5: both read continuously; the log predicts the alternating returns.
    set_m0(0, 1, 30'h100, '0, 4'hF);
    set_m1(0, 1, 30'h200, '0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      s_readdata = $urandom;
      tick();
    end
    idle();
    repeat (3) tick();

    // 6: reset right after an accepted read kills the return; next tie to m0.
    set_m0(0, 1, 30'h300, '0, 4'hF);
    tick();
    idle();
    do_reset(1);
    half();
    check("t6_rdv0_d1", d1_m0_rdv, 1'b0);
    edge_();
    tick();
    set_m0(1, 0, 30'h11, 32'h5, 4'h3);
    set_m1(1, 0, 30'h22, 32'h6, 4'hC);
    half();
    check("t6_tie_wait1", d1_m1_wait, 1'b1);
    check("t6_tie_addr", d2_s_addr, 30'h11);
    edge_();
    idle(); tick();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      set_m0($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             ADDR_W'($urandom), $urandom, BE_W'($urandom));
      set_m1($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             ADDR_W'($urandom), $urandom, BE_W'($urandom));
      s_readdata = $urandom;
      if ($urandom_range(0, 63) == 0) do_reset($urandom_range(1, 2));
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
